// File: rtl/educ8_major_state_ctrl_if.sv
// Front-panel, instruction-decode and datapath-strobe bundle for the EDUC-8
// major-state sequencer. The master side is the CPU/panel environment that
// drives requests and decode bits; the slave side is the sequencer itself.
interface educ8_major_state_ctrl_if;
   logic        run_req;
   logic        halt_req;
   logic        step_mode;
   logic [2:0]  opcode;
   logic        ind;
   logic        skip;
   logic        hlt;
   logic        running;
   logic [2:0]  major;
   logic [15:0] tslot;
   logic        ma_ld_pc;
   logic        ma_ld_md;
   logic        mem_rd;
   logic        mem_wr;
   logic        ir_ld;
   logic        pc_inc;
   logic        pc_ld;
   logic        exec_stb;

   modport master (
      output run_req, halt_req, step_mode, opcode, ind, skip, hlt,
      input  running, major, tslot,
      input  ma_ld_pc, ma_ld_md, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, exec_stb
   );

   modport slave (
      input  run_req, halt_req, step_mode, opcode, ind, skip, hlt,
      output running, major, tslot,
      output ma_ld_pc, ma_ld_md, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, exec_stb
   );
endinterface

// File: rtl/educ8_major_state_ctrl.sv
// EDUC-8 major-state and timing-slot sequencer. Each instruction walks
// FETCH, optionally DEFER, and usually EXEC, each NSLOT slots long, and the
// registered state is decoded into one-slot-wide register-transfer strobes.
// Halts only ever take effect at an instruction boundary, so a major cycle is
// never cut short.
module educ8_major_state_ctrl #(
   parameter int NSLOT = 8
) (
   input logic                     clk,
   input logic                     clr,
   educ8_major_state_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      FETCH = 3'b001,
      DEFER = 3'b010,
      EXEC  = 3'b100
   } major_t;

   localparam logic [3:0] LAST_SLOT = 4'(NSLOT - 1);

   logic       r_running;
   major_t     r_major;
   logic [3:0] r_slot;
   logic       r_haltPend;

   logic       w_nextRunning;
   major_t     w_nextMajor;
   major_t     w_wrapMajor;
   logic [3:0] w_nextSlot;
   logic       w_nextHaltPend;

   logic       w_wrap;
   logic       w_memref;
   logic       w_jmp;

   logic       w_maLdPc;
   logic       w_maLdMd;
   logic       w_memRd;
   logic       w_memWr;
   logic       w_irLd;
   logic       w_pcInc;
   logic       w_pcLd;
   logic       w_execStb;

   assign w_wrap   = (r_slot == LAST_SLOT);
   assign w_memref = (bus.opcode <= 3'd5);
   assign w_jmp    = (bus.opcode == 3'd5);

   // State register; clr drops straight back to a halted FETCH T0.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_running  <= 1'b0;
         r_major    <= FETCH;
         r_slot     <= 4'd0;
         r_haltPend <= 1'b0;
      end else begin
         r_running  <= w_nextRunning;
         r_major    <= w_nextMajor;
         r_slot     <= w_nextSlot;
         r_haltPend <= w_nextHaltPend;
      end
   end

   // Major cycle that follows the current one when the slot counter wraps.
   always_comb begin
      w_wrapMajor = FETCH;
      case (r_major)
         FETCH: begin
            if (w_memref && bus.ind) begin
               w_wrapMajor = DEFER;
            end else if (w_jmp) begin
               w_wrapMajor = FETCH;
            end else begin
               w_wrapMajor = EXEC;
            end
         end
         DEFER:   w_wrapMajor = w_jmp ? FETCH : EXEC;
         default: w_wrapMajor = FETCH;
      endcase
   end

   // Run/halt control and slot sequencing; a wrap back into FETCH is the
   // instruction boundary where any pending halt is honoured.
   always_comb begin
      w_nextRunning  = r_running;
      w_nextMajor    = r_major;
      w_nextSlot     = r_slot;
      w_nextHaltPend = r_haltPend;
      if (!r_running) begin
         if (bus.run_req) begin
            w_nextRunning  = 1'b1;
            w_nextMajor    = FETCH;
            w_nextSlot     = 4'd0;
            w_nextHaltPend = bus.halt_req;
         end
      end else begin
         if (bus.halt_req) begin
            w_nextHaltPend = 1'b1;
         end
         if ((r_major == EXEC) && (r_slot == 4'd2) && bus.hlt) begin
            w_nextHaltPend = 1'b1;
         end
         if (w_wrap) begin
            w_nextSlot  = 4'd0;
            w_nextMajor = w_wrapMajor;
            if ((w_wrapMajor == FETCH) && (r_haltPend || bus.step_mode)) begin
               w_nextRunning  = 1'b0;
               w_nextMajor    = FETCH;
               w_nextHaltPend = 1'b0;
            end
         end else begin
            w_nextSlot = r_slot + 4'd1;
         end
      end
   end

   // Register-transfer strobes decoded from major cycle, slot and opcode;
   // everything stays quiet while halted.
   always_comb begin
      w_maLdPc  = 1'b0;
      w_maLdMd  = 1'b0;
      w_memRd   = 1'b0;
      w_memWr   = 1'b0;
      w_irLd    = 1'b0;
      w_pcInc   = 1'b0;
      w_pcLd    = 1'b0;
      w_execStb = 1'b0;
      if (r_running) begin
         case (r_major)
            FETCH: begin
               case (r_slot)
                  4'd0:    w_maLdPc = 1'b1;
                  4'd1:    w_memRd  = 1'b1;
                  4'd2:    w_irLd   = 1'b1;
                  4'd3:    w_pcInc  = 1'b1;
                  4'd4:    w_maLdMd = w_memref;
                  4'd5:    w_pcLd   = w_jmp && !bus.ind;
                  default: ;
               endcase
            end
            DEFER: begin
               case (r_slot)
                  4'd1:    w_memRd  = 1'b1;
                  4'd2:    w_maLdMd = 1'b1;
                  4'd3:    w_pcLd   = w_jmp;
                  default: ;
               endcase
            end
            EXEC: begin
               case (r_slot)
                  4'd1:    w_memRd   = (bus.opcode <= 3'd2);
                  4'd2:    w_execStb = 1'b1;
                  4'd3:    w_memWr   = (bus.opcode >= 3'd2) && (bus.opcode <= 3'd4);
                  4'd4:    w_pcLd    = (bus.opcode == 3'd4);
                  4'd5:    w_pcInc   = bus.skip && ((bus.opcode == 3'd2) || (bus.opcode >= 3'd6));
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign bus.running  = r_running;
   assign bus.major    = r_major;
   assign bus.tslot    = r_running ? (16'd1 << r_slot) : 16'd0;
   assign bus.ma_ld_pc = w_maLdPc;
   assign bus.ma_ld_md = w_maLdMd;
   assign bus.mem_rd   = w_memRd;
   assign bus.mem_wr   = w_memWr;
   assign bus.ir_ld    = w_irLd;
   assign bus.pc_inc   = w_pcInc;
   assign bus.pc_ld    = w_pcLd;
   assign bus.exec_stb = w_execStb;

endmodule

// File: tb/tb_educ8_major_state_ctrl.sv
// Scoreboard bench for the EDUC-8 major-state sequencer. Expected per-cycle
// output vectors are built from the instruction timing table as each
// instruction is launched, then popped and compared cycle by cycle.
module tb_educ8_major_state_ctrl;

   localparam int NSLOT = 8;
   localparam logic [2:0] M_FETCH = 3'b001;
   localparam logic [2:0] M_DEFER = 3'b010;
   localparam logic [2:0] M_EXEC  = 3'b100;
   // Packed vector: {4'b0, running, major[2:0], tslot[15:0], strobes[7:0]}
   // strobes = {ma_ld_pc, ma_ld_md, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, exec_stb}
   localparam logic [31:0] HALTED = {4'b0000, 1'b0, M_FETCH, 16'h0000, 8'h00};

   logic clk = 1'b0;
   logic clr;

   educ8_major_state_ctrl_if bus ();

   educ8_major_state_ctrl #(.NSLOT(NSLOT)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   int          assertCount = 0;
   int          failCount   = 0;
   logic [31:0] expQ[$];

   function automatic logic [31:0] observed();
      return {4'b0000, bus.running, bus.major, bus.tslot,
              bus.ma_ld_pc, bus.ma_ld_md, bus.mem_rd, bus.mem_wr,
              bus.ir_ld, bus.pc_inc, bus.pc_ld, bus.exec_stb};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Strobes the timing table calls for in one slot of one major cycle.
   function automatic logic [7:0] expStrobes(input logic [2:0] maj, input int t,
                                             input int op, input logic ind, input logic skp);
      logic maPc, maMd, rd, wr, irl, inc, ld, ex;
      maPc = 0; maMd = 0; rd = 0; wr = 0; irl = 0; inc = 0; ld = 0; ex = 0;
      if (maj == M_FETCH) begin
         if (t == 0) maPc = 1;
         if (t == 1) rd = 1;
         if (t == 2) irl = 1;
         if (t == 3) inc = 1;
         if (t == 4 && op <= 5) maMd = 1;
         if (t == 5 && op == 5 && !ind) ld = 1;
      end else if (maj == M_DEFER) begin
         if (t == 1) rd = 1;
         if (t == 2) maMd = 1;
         if (t == 3 && op == 5) ld = 1;
      end else begin
         if (t == 1 && (op == 0 || op == 1 || op == 2)) rd = 1;
         if (t == 2) ex = 1;
         if (t == 3 && (op == 2 || op == 3 || op == 4)) wr = 1;
         if (t == 4 && op == 4) ld = 1;
         if (t == 5 && skp && (op == 2 || op == 6 || op == 7)) inc = 1;
      end
      return {maPc, maMd, rd, wr, irl, inc, ld, ex};
   endfunction

   task automatic pushMajor(input logic [2:0] maj, input int op, input logic ind, input logic skp);
      logic [15:0] oneHot;
      for (int t = 0; t < NSLOT; t++) begin
         oneHot = 16'd1 << t;
         expQ.push_back({4'b0000, 1'b1, maj, oneHot, expStrobes(maj, t, op, ind, skp)});
      end
   endtask

   // Expected trace of one whole instruction, optionally followed by the
   // halted cycle it should leave behind.
   task automatic pushInstr(input int op, input logic ind, input logic skp, input bit haltAfter);
      pushMajor(M_FETCH, op, ind, skp);
      if (op <= 5 && ind) pushMajor(M_DEFER, op, ind, skp);
      if (op != 5) pushMajor(M_EXEC, op, ind, skp);
      if (haltAfter) expQ.push_back(HALTED);
   endtask

   task automatic pushHalted(input int n);
      for (int k = 0; k < n; k++) expQ.push_back(HALTED);
   endtask

   task automatic setDecode(input int op, input logic ind, input logic skp, input logic hl, input logic stp);
      bus.opcode    = 3'(op);
      bus.ind       = ind;
      bus.skip      = skp;
      bus.hlt       = hl;
      bus.step_mode = stp;
   endtask

   // Runs nSteps clock cycles, pulsing run_req/halt_req on the chosen steps
   // and comparing each cycle's outputs against the scoreboard head.
   task automatic applyStimulus(input string tag, input int nSteps, input int runAt, input int hreqAt);
      logic [31:0] expv;
      for (int i = 0; i < nSteps; i++) begin
         @(posedge clk);
         #2;
         bus.run_req  = (i == runAt);
         bus.halt_req = (i == hreqAt);
         #1;
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s step %0d: observed %h expected none queued", tag, i, observed());
         end else begin
            expv = expQ.pop_front();
            checkOutput($sformatf("%s step %0d", tag, i), observed(), expv);
         end
      end
      bus.run_req  = 1'b0;
      bus.halt_req = 1'b0;
   endtask

   initial begin
      logic [31:0] expv;
      clr          = 1'b1;
      bus.run_req  = 1'b0;
      bus.halt_req = 1'b0;
      setDecode(0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      checkOutput("resetHeld", observed(), HALTED);
      @(posedge clk);
      #2;
      clr = 1'b0;

      $display("[TB] TAD free run, halt_req at FETCH T1 of second instruction");
      setDecode(1, 0, 0, 0, 0);
      pushHalted(1);
      pushInstr(1, 0, 0, 0);
      pushInstr(1, 0, 0, 1);
      applyStimulus("tadRun", 1 + 2 * 2 * NSLOT + 1, 0, 1 + 2 * NSLOT + 1);

      $display("[TB] ISZ indirect with skip, single-step");
      setDecode(2, 1, 1, 0, 1);
      pushHalted(1);
      pushInstr(2, 1, 1, 1);
      applyStimulus("iszIndSkip", 1 + 3 * NSLOT + 1, 0, -1);

      setDecode(2, 1, 0, 0, 1);
      pushHalted(1);
      pushInstr(2, 1, 0, 1);
      applyStimulus("iszIndNoSkip", 1 + 3 * NSLOT + 1, 0, -1);

      $display("[TB] JMP direct loop");
      setDecode(5, 0, 0, 0, 0);
      pushHalted(1);
      pushInstr(5, 0, 0, 0);
      pushInstr(5, 0, 0, 0);
      pushInstr(5, 0, 0, 1);
      applyStimulus("jmpDir", 1 + 3 * NSLOT + 1, 0, 1 + 2 * NSLOT + 1);

      setDecode(5, 1, 0, 0, 1);
      pushHalted(1);
      pushInstr(5, 1, 0, 1);
      applyStimulus("jmpInd", 1 + 2 * NSLOT + 1, 0, -1);

      $display("[TB] OPR HLT, IOT skip, JMS, DCA indirect, AND");
      setDecode(7, 1, 0, 1, 0);
      pushHalted(1);
      pushInstr(7, 1, 0, 1);
      applyStimulus("oprHlt", 1 + 2 * NSLOT + 1, 0, -1);

      setDecode(6, 0, 1, 0, 1);
      pushHalted(1);
      pushInstr(6, 0, 1, 1);
      applyStimulus("iotSkip", 1 + 2 * NSLOT + 1, 0, -1);

      setDecode(4, 0, 1, 0, 1);
      pushHalted(1);
      pushInstr(4, 0, 1, 1);
      applyStimulus("jms", 1 + 2 * NSLOT + 1, 0, -1);

      setDecode(3, 1, 0, 0, 1);
      pushHalted(1);
      pushInstr(3, 1, 0, 1);
      applyStimulus("dcaInd", 1 + 3 * NSLOT + 1, 0, -1);

      setDecode(0, 0, 0, 0, 1);
      pushHalted(1);
      pushInstr(0, 0, 0, 1);
      applyStimulus("and", 1 + 2 * NSLOT + 1, 0, -1);

      $display("[TB] single-step: one instruction per run_req");
      for (int p = 0; p < 2; p++) begin
         setDecode(1, 0, 0, 0, 1);
         pushHalted(1);
         pushInstr(1, 0, 0, 1);
         pushHalted(2);
         applyStimulus($sformatf("step%0d", p), 1 + 2 * NSLOT + 1 + 2, 0, -1);
      end

      $display("[TB] simultaneous run_req and halt_req while halted");
      setDecode(1, 0, 0, 0, 0);
      pushHalted(1);
      pushInstr(1, 0, 0, 1);
      applyStimulus("runHalt", 1 + 2 * NSLOT + 1, 0, 0);

      pushHalted(3);
      applyStimulus("haltWhileHalted", 3, -1, 1);

      setDecode(3, 0, 0, 0, 0);
      pushHalted(1);
      pushInstr(3, 0, 0, 0);
      pushInstr(3, 0, 0, 1);
      applyStimulus("noStaleHalt", 1 + 4 * NSLOT + 1, 0, 1 + 2 * NSLOT + 1);

      $display("[TB] clr mid EXEC T3");
      setDecode(2, 0, 0, 0, 0);
      pushHalted(1);
      pushInstr(2, 0, 0, 0);
      applyStimulus("clrLead", 1 + NSLOT + 3, 0, -1);
      @(posedge clk);
      #3;
      checkOutput("memWrBeforeClr", {31'd0, bus.mem_wr}, 32'd1);
      expv = expQ.pop_front();
      checkOutput("execT3BeforeClr", observed(), expv);
      clr = 1'b1;
      #1;
      checkOutput("clrAsync", observed(), HALTED);
      expQ.delete();
      @(posedge clk);
      #3;
      checkOutput("clrHeld", observed(), HALTED);
      clr = 1'b0;

      setDecode(1, 0, 0, 0, 1);
      pushHalted(1);
      pushInstr(1, 0, 0, 1);
      applyStimulus("afterClr", 1 + 2 * NSLOT + 1, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
